cache_ctrl: RTL and testbench

CACHE_CTRL -- requirements
Module: cache_ctrl

---
 rtl/cache_pkg.sv | 8 +
 rtl/cache_array.sv | 48 ++++
 rtl/cache_ctrl.sv | 126 ++++++++++++
 tb/tb_cache_ctrl.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// cache_pkg: shared widths, default geometry/latency and controller state encoding
package cache_pkg;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int LINES_DEF = 16;
  localparam int MM_LAT_DEF = 2;
  typedef enum logic [1:0] {IDLE, MEMRD, MEMWR, RESP} state_t;
endpackage

// File: rtl/cache_array.sv
// cache_array: direct-mapped tag/valid/data store; async read port (rd_idx/rd_tag -> hit/rd_data), one write port (we/wr_*), valid cleared on reset
module cache_array
  import cache_pkg::*;
#(
  parameter int LINES = LINES_DEF,
  localparam int IW = $clog2(LINES),
  localparam int TW = AW - IW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [IW-1:0] rd_idx,
  input  logic [TW-1:0] rd_tag,
  output logic          hit,
  output logic [DW-1:0] rd_data,
  input  logic          we,
  input  logic [IW-1:0] wr_idx,
  input  logic [TW-1:0] wr_tag,
  input  logic [DW-1:0] wr_data
);
  logic [LINES-1:0] valid_q, valid_d;
  logic [TW-1:0] tag_q [LINES];
  logic [TW-1:0] tag_d [LINES];
  logic [DW-1:0] data_q [LINES];
  logic [DW-1:0] data_d [LINES];
  assign hit = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_data = data_q[rd_idx];
  always_comb begin
    valid_d = valid_q;
    tag_d = tag_q;
    data_d = data_q;
    if (we) begin
      valid_d[wr_idx] = 1'b1;
      tag_d[wr_idx] = wr_tag;
      data_d[wr_idx] = wr_data;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      tag_q <= '{default: '0};
      data_q <= '{default: '0};
    end else begin
      valid_q <= valid_d;
      tag_q <= tag_d;
      data_q <= data_d;
    end
  end
endmodule

// File: rtl/cache_ctrl.sv
// cache_ctrl: write-through, no-write-allocate direct-mapped cache controller; CPU side (CPURead/CPUWrite/CPUAddr/CPUDataIn -> CPUDataOut/Done), memory side (MMRead/MMWrite/ABUS/CachetoMem <- MemtoCache)
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int MM_LAT = MM_LAT_DEF,
  parameter int LINES = LINES_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          CPURead,
  input  logic          CPUWrite,
  input  logic [AW-1:0] CPUAddr,
  input  logic [DW-1:0] CPUDataIn,
  output logic [DW-1:0] CPUDataOut,
  output logic          Done,
  output logic          MMRead,
  output logic          MMWrite,
  output logic [AW-1:0] ABUS,
  output logic [DW-1:0] CachetoMem,
  input  logic [DW-1:0] MemtoCache
);
  localparam int IW = $clog2(LINES);
  localparam int CW = MM_LAT > 1 ? $clog2(MM_LAT) : 1;
  localparam logic [CW-1:0] LAST = CW'(MM_LAT - 1);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic done_q, done_d, mmrd_q, mmrd_d, mmwr_q, mmwr_d;
  logic [AW-1:0] abus_q, abus_d;
  logic [DW-1:0] c2m_q, c2m_d, dout_q, dout_d;
  logic hit, arr_we;
  logic [DW-1:0] rd_data, arr_wdata;
  cache_array #(.LINES(LINES)) u_array (
    .clk     (clk),
    .reset   (reset),
    .rd_idx  (CPUAddr[IW-1:0]),
    .rd_tag  (CPUAddr[AW-1:IW]),
    .hit     (hit),
    .rd_data (rd_data),
    .we      (arr_we),
    .wr_idx  (CPUAddr[IW-1:0]),
    .wr_tag  (CPUAddr[AW-1:IW]),
    .wr_data (arr_wdata)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    done_d = 1'b0;
    mmrd_d = 1'b0;
    mmwr_d = 1'b0;
    abus_d = abus_q;
    c2m_d = c2m_q;
    dout_d = dout_q;
    arr_we = 1'b0;
    arr_wdata = CPUDataIn;
    case (state_q)
      IDLE: begin
        if (CPUWrite) begin
          state_d = MEMWR;
          mmwr_d = 1'b1;
          abus_d = CPUAddr;
          c2m_d = CPUDataIn;
          cnt_d = '0;
          arr_we = hit;
        end else if (CPURead && hit) begin
          state_d = RESP;
          done_d = 1'b1;
          dout_d = rd_data;
        end else if (CPURead) begin
          state_d = MEMRD;
          mmrd_d = 1'b1;
          abus_d = CPUAddr;
          cnt_d = '0;
        end
      end
      MEMRD: begin
        if (cnt_q == LAST) begin
          state_d = RESP;
          done_d = 1'b1;
          dout_d = MemtoCache;
          arr_we = 1'b1;
          arr_wdata = MemtoCache;
        end else begin
          mmrd_d = 1'b1;
          cnt_d = cnt_q + 1'b1;
        end
      end
      MEMWR: begin
        if (cnt_q == LAST) begin
          state_d = RESP;
          done_d = 1'b1;
        end else begin
          mmwr_d = 1'b1;
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      done_q <= 1'b0;
      mmrd_q <= 1'b0;
      mmwr_q <= 1'b0;
      abus_q <= '0;
      c2m_q <= '0;
      dout_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      done_q <= done_d;
      mmrd_q <= mmrd_d;
      mmwr_q <= mmwr_d;
      abus_q <= abus_d;
      c2m_q <= c2m_d;
      dout_q <= dout_d;
    end
  end
  assign Done = done_q;
  assign MMRead = mmrd_q;
  assign MMWrite = mmwr_q;
  assign ABUS = abus_q;
  assign CachetoMem = c2m_q;
  assign CPUDataOut = dout_q;
endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: directed table, reset corner cases and random traffic against a residency-based cache model
module tb_cache_ctrl;
  localparam int MM_LAT = 2;
  logic clk = 1'b0, reset = 1'b1, CPURead = 1'b0, CPUWrite = 1'b0;
  logic [7:0] CPUAddr = '0, CPUDataIn = '0, MemtoCache;
  logic [7:0] CPUDataOut, ABUS, CachetoMem;
  logic Done, MMRead, MMWrite;
  logic [7:0] mem [256];
  logic [7:0] mm [256];
  int line_addr [16];
  int passed = 0, total = 0;
  typedef struct {
    bit rd;
    bit wr;
    logic [7:0] addr;
    logic [7:0] din;
    int lat;
    int nrd;
    int nwr;
    logic [7:0] dout;
    bit chk;
  } vec_t;
  vec_t tbl [10];
  cache_ctrl #(.MM_LAT(MM_LAT), .LINES(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .CPURead    (CPURead),
    .CPUWrite   (CPUWrite),
    .CPUAddr    (CPUAddr),
    .CPUDataIn  (CPUDataIn),
    .CPUDataOut (CPUDataOut),
    .Done       (Done),
    .MMRead     (MMRead),
    .MMWrite    (MMWrite),
    .ABUS       (ABUS),
    .CachetoMem (CachetoMem),
    .MemtoCache (MemtoCache)
  );
  always #5 clk = ~clk;
  assign MemtoCache = mem[ABUS];
  always @(posedge clk) if (MMWrite) mem[ABUS] <= CachetoMem;
  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", n, act, exp);
  endtask
  task automatic model_reset();
    for (int i = 0; i < 16; i++) line_addr[i] = -1;
  endtask
  // A line holds at most one address; write-through keeps cached data equal to memory.
  task automatic model(input bit rd, input bit wr, input logic [7:0] a, input logic [7:0] d,
                       output int lat, output int nrd, output int nwr, output logic [7:0] dout, output bit c);
    bit hit;
    hit = (line_addr[a % 16] == int'(a));
    nrd = 0; nwr = 0; c = 0; dout = '0;
    if (wr) begin
      mm[a] = d; lat = MM_LAT + 1; nwr = MM_LAT;
    end else begin
      c = 1;
      if (hit) lat = 1;
      else begin
        lat = MM_LAT + 1; nrd = MM_LAT; line_addr[a % 16] = int'(a);
      end
      dout = mm[a];
    end
    if (!rd && !wr) lat = 0;
  endtask
  task automatic xact(input bit rd, input bit wr, input logic [7:0] a, input logic [7:0] d,
                      output int lat, output int nrd, output int nwr, output int bad, output logic [7:0] dout);
    CPURead = rd; CPUWrite = wr; CPUAddr = a; CPUDataIn = d;
    lat = 0; nrd = 0; nwr = 0; bad = 0; dout = '0;
    for (int c = 1; c <= 50 && lat == 0; c++) begin
      @(posedge clk); #1;
      if (MMRead && MMWrite) bad++;
      if (MMRead) begin nrd++; if (ABUS !== a) bad++; end
      if (MMWrite) begin nwr++; if (ABUS !== a || CachetoMem !== d) bad++; end
      if (Done === 1'b1) begin lat = c; dout = CPUDataOut; end
    end
    CPURead = 1'b0; CPUWrite = 1'b0;
    @(posedge clk); #1;
    if (Done !== 1'b0) bad++;
  endtask
  task automatic run(input string n, input bit rd, input bit wr, input logic [7:0] a, input logic [7:0] d,
                     input int elat, input int enrd, input int enwr, input logic [7:0] edout, input bit echk);
    int lat, nrd, nwr, bad;
    logic [7:0] dout;
    xact(rd, wr, a, d, lat, nrd, nwr, bad, dout);
    chk({n, " latency"}, lat, elat);
    chk({n, " mmread_cycles"}, nrd, enrd);
    chk({n, " mmwrite_cycles"}, nwr, enwr);
    chk({n, " bus_protocol_errors"}, bad, 0);
    if (echk) chk({n, " dataout"}, int'(dout), int'(edout));
  endtask
  initial begin
    int lat, nrd, nwr;
    logic [7:0] dout, a, d;
    bit c, rd, wr;
    for (int i = 0; i < 256; i++) begin mem[i] = 8'($urandom); mm[i] = mem[i]; end
    mem[8'h35] = 8'hA7; mm[8'h35] = 8'hA7;
    mem[8'h45] = 8'h3B; mm[8'h45] = 8'h3B;
    model_reset();
    tbl[0] = '{1, 0, 8'h35, 8'h00, 3, 2, 0, 8'hA7, 1};
    tbl[1] = '{1, 0, 8'h35, 8'h00, 1, 0, 0, 8'hA7, 1};
    tbl[2] = '{1, 0, 8'h45, 8'h00, 3, 2, 0, 8'h3B, 1};
    tbl[3] = '{1, 0, 8'h35, 8'h00, 3, 2, 0, 8'hA7, 1};
    tbl[4] = '{0, 1, 8'h35, 8'h5C, 3, 0, 2, 8'h00, 0};
    tbl[5] = '{1, 0, 8'h35, 8'h00, 1, 0, 0, 8'h5C, 1};
    tbl[6] = '{0, 1, 8'h90, 8'h11, 3, 0, 2, 8'h00, 0};
    tbl[7] = '{1, 0, 8'h90, 8'h00, 3, 2, 0, 8'h11, 1};
    tbl[8] = '{1, 1, 8'h20, 8'h77, 3, 0, 2, 8'h00, 0};
    tbl[9] = '{1, 0, 8'h20, 8'h00, 3, 2, 0, 8'h77, 1};
    CPURead = 1'b1; CPUAddr = 8'h35;
    repeat (3) @(posedge clk);
    #1;
    chk("reset done", int'(Done), 0);
    chk("reset mmread", int'(MMRead), 0);
    chk("reset mmwrite", int'(MMWrite), 0);
    chk("reset abus", int'(ABUS), 0);
    chk("reset cachetomem", int'(CachetoMem), 0);
    chk("reset dataout", int'(CPUDataOut), 0);
    CPURead = 1'b0; reset = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      model(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].din, lat, nrd, nwr, dout, c);
      run($sformatf("vec%0d", i), tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].din,
          tbl[i].lat, tbl[i].nrd, tbl[i].nwr, tbl[i].dout, tbl[i].chk);
    end
    CPURead = 1'b1; CPUAddr = 8'h55;
    @(posedge clk); #1;
    chk("abort mmread_c1", int'(MMRead), 1);
    @(posedge clk); #1;
    chk("abort mmread_c2", int'(MMRead), 1);
    reset = 1'b1; CPURead = 1'b0;
    @(posedge clk); #1;
    chk("abort mmread", int'(MMRead), 0);
    chk("abort done", int'(Done), 0);
    chk("abort abus", int'(ABUS), 0);
    reset = 1'b0;
    model_reset();
    @(posedge clk); #1;
    chk("abort still_idle_done", int'(Done), 0);
    model(1, 0, 8'h55, 8'h00, lat, nrd, nwr, dout, c);
    run("reissue55", 1, 0, 8'h55, 8'h00, lat, nrd, nwr, dout, c);
    model(1, 0, 8'h35, 8'h00, lat, nrd, nwr, dout, c);
    run("post_reset35", 1, 0, 8'h35, 8'h00, lat, nrd, nwr, dout, c);
    for (int i = 0; i < 60; i++) begin
      a = 8'($urandom_range(0, 3) * 16 + $urandom_range(0, 3));
      d = 8'($urandom);
      rd = 1'($urandom_range(0, 1));
      wr = rd ? ($urandom_range(0, 3) == 0) : 1'b1;
      model(rd, wr, a, d, lat, nrd, nwr, dout, c);
      run($sformatf("rnd%0d", i), rd, wr, a, d, lat, nrd, nwr, dout, c);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
